// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter with registered one-hot grant, hold cap and one recover cycle (RR_DECODE_ARBITER_LOCK_EN adds i_lock)
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_req,
  input  logic       i_release,
`ifdef RR_DECODE_ARBITER_LOCK_EN
  input  logic       i_lock,
`endif
  output logic [7:0] o_gnt,
  output logic [2:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_busy
);
  // bit 1 = busy, bit 0 = owner valid, so both outputs are plain register bits
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RECOVER = 2'b10;
  localparam logic [1:0] GRANT   = 2'b11;
  logic [1:0]        r_state;
  logic [2:0]        r_ptr;
  logic [2:0]        r_idx;
  logic [7:0]        r_gnt;
  logic [HOLD_W-1:0] r_hold;
  logic [2:0]        w_win;
  logic              w_lock;
  logic              w_cap;
  logic              w_exit;
`ifdef RR_DECODE_ARBITER_LOCK_EN
  assign w_lock = i_lock;
`else
  assign w_lock = 1'b0;
`endif
  assign w_cap  = r_hold == HOLD_W'(MAX_HOLD);
  assign w_exit = i_release | ~i_req[r_idx] | (w_cap & ~w_lock);
  // first requester after the previous owner wins; the previous owner itself is searched last
  always_comb begin
    w_win = '0;
    for (int k = 8; k >= 1; k--)
      if (i_req[3'(r_ptr + 3'(k))]) w_win = 3'(r_ptr + 3'(k));
  end
  // arbitration FSM: IDLE picks, GRANT holds up to the cap, RECOVER forces one dead cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd7;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: if (|i_req) begin
          r_state <= GRANT;
          r_idx   <= w_win;
          r_gnt   <= 8'b1 << w_win;
          r_hold  <= HOLD_W'(1);
        end
        GRANT: if (w_exit) begin
          r_state <= RECOVER;
          r_ptr   <= r_idx;
          r_idx   <= '0;
          r_gnt   <= '0;
          r_hold  <= '0;
        end else if (!w_cap) r_hold <= r_hold + HOLD_W'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_idx;
  assign o_gnt_valid = r_state[0];
  assign o_busy      = r_state[1];
endmodule
